// File: rtl/apu_core_package.sv
// rtl/apu_core_package.sv - shared APU op/latency codes and response queue entry type
package apu_core_package;

    // Queue entries are sized for the default responder configuration
    localparam int APU_RESP_WIDTH = 32;
    localparam int APU_RESP_TAG_W = 6;

    localparam logic [2:0] APU_OP_ADD = 3'd0;
    localparam logic [2:0] APU_OP_SUB = 3'd1;
    localparam logic [2:0] APU_OP_AND = 3'd2;
    localparam logic [2:0] APU_OP_OR  = 3'd3;
    localparam logic [2:0] APU_OP_XOR = 3'd4;
    localparam logic [2:0] APU_OP_MUL = 3'd5;

    localparam logic [1:0] APU_LAT_1     = 2'h0;
    localparam logic [1:0] APU_LAT_2     = 2'h1;
    localparam logic [1:0] APU_LAT_3     = 2'h2;
    localparam logic [1:0] APU_LAT_MULTI = 2'h3;

    typedef struct packed {
        logic [APU_RESP_TAG_W-1:0] tag;
        logic [APU_RESP_WIDTH-1:0] result;
        logic [2:0]                flags;
        logic [3:0]                cnt;
    } apu_resp_entry_t;

    function automatic logic [3:0] apu_lat_cycles(input logic [1:0] lat, input logic [3:0] multi_lat);
        case (lat)
            APU_LAT_1: return 4'd1;
            APU_LAT_2: return 4'd2;
            APU_LAT_3: return 4'd3;
            default:   return multi_lat;
        endcase
    endfunction

endpackage

// File: rtl/riscv_apu_resp_alu.sv
// rtl/riscv_apu_resp_alu.sv - combinational APU op unit; op 5 multiplies only with APU_RESP_MUL_EN defined
module riscv_apu_resp_alu
    import apu_core_package::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [2:0]       o_flags
);

    logic [WIDTH-1:0] w_res;
    logic             w_ill;
    logic             w_ovf;

    always_comb begin
        w_res = '0;
        w_ill = 1'b0;
        w_ovf = 1'b0;
        case (i_op)
            APU_OP_ADD: begin
                w_res = i_a + i_b;
                w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            APU_OP_SUB: begin
                w_res = i_a - i_b;
                w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_res[WIDTH-1] != i_a[WIDTH-1]);
            end
            APU_OP_AND: w_res = i_a & i_b;
            APU_OP_OR:  w_res = i_a | i_b;
            APU_OP_XOR: w_res = i_a ^ i_b;
`ifdef APU_RESP_MUL_EN
            APU_OP_MUL: w_res = i_a * i_b;
`else
            APU_OP_MUL: w_ill = 1'b1;
`endif
            default:    w_ill = 1'b1;
        endcase
    end

    // Illegal ops report only the illegal bit, never zero
    assign o_result = w_res;
    assign o_flags  = {w_ill, w_ovf, ~w_ill & (w_res == '0)};

endmodule

// File: rtl/riscv_apu_resp.sv
// rtl/riscv_apu_resp.sv - in-order 2-entry APU responder (multiplier gated by APU_RESP_MUL_EN)
module riscv_apu_resp
    import apu_core_package::*;
#(
    parameter int WIDTH     = APU_RESP_WIDTH,
    parameter int TAG_W     = APU_RESP_TAG_W,
    parameter int MULTI_LAT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             apu_slave_req_i,
    output logic             apu_slave_gnt_o,
    input  logic [2:0]       apu_slave_op_i,
    input  logic [1:0]       apu_slave_lat_i,
    input  logic [WIDTH-1:0] apu_slave_operand_a_i,
    input  logic [WIDTH-1:0] apu_slave_operand_b_i,
    input  logic [TAG_W-1:0] apu_slave_tag_i,
    input  logic             apu_slave_ready_i,
    output logic             apu_slave_valid_o,
    output logic [WIDTH-1:0] apu_slave_result_o,
    output logic [2:0]       apu_slave_flags_o,
    output logic [TAG_W-1:0] apu_slave_tag_o,
    output logic             busy_o
);

    apu_resp_entry_t r_entry [2];
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;

    logic [WIDTH-1:0] w_alu_result;
    logic [2:0]       w_alu_flags;
    logic [3:0]       w_lat;
    logic [3:0]       w_tail_cnt;
    logic             w_valid;
    logic             w_pop;
    logic             w_order_ok;
    logic             w_push;
    logic [1:0]       w_occ;

    riscv_apu_resp_alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (apu_slave_op_i),
        .i_a      (apu_slave_operand_a_i),
        .i_b      (apu_slave_operand_b_i),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    assign w_lat      = apu_lat_cycles(apu_slave_lat_i, 4'(MULTI_LAT));
    // The most recently pushed entry sits just behind the tail pointer
    assign w_tail_cnt = r_entry[~r_tail].cnt;
    assign w_valid    = (r_count != 2'd0) && (r_entry[r_head].cnt == 4'd0);
    assign w_pop      = w_valid & apu_slave_ready_i;
    assign w_order_ok = (r_count == 2'd0) || (w_lat > w_tail_cnt);
    assign w_push     = rst_ni & apu_slave_req_i & ((r_count < 2'd2) | w_pop) & w_order_ok;

    assign w_occ[0] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b0));
    assign w_occ[1] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'b1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_entry[0] <= '0;
            r_entry[1] <= '0;
            r_head     <= 1'b0;
            r_tail     <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_occ[i] && (r_entry[i].cnt != 4'd0)) begin
                    r_entry[i].cnt <= r_entry[i].cnt - 4'd1;
                end
            end
            // A push into the slot being popped overrides its countdown above
            if (w_push) begin
                r_entry[r_tail] <= '{tag:    apu_slave_tag_i,
                                     result: w_alu_result,
                                     flags:  w_alu_flags,
                                     cnt:    w_lat - 4'd1};
                r_tail <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign apu_slave_gnt_o    = w_push;
    assign apu_slave_valid_o  = w_valid;
    assign apu_slave_result_o = w_valid ? r_entry[r_head].result : '0;
    assign apu_slave_flags_o  = w_valid ? r_entry[r_head].flags  : 3'b000;
    assign apu_slave_tag_o    = w_valid ? r_entry[r_head].tag    : '0;
    assign busy_o             = (r_count != 2'd0);

endmodule
